// File: rtl/uart_tx_ctrl_if.sv
// Handshake/bus bundle between the UART transmit producer and the frame sequencer.
// The master drives the payload and strobe; the slave (sequencer) drives mux control.
interface uart_tx_ctrl_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [1:0]            mux_sel;
   logic                  ser_data;
   logic                  par_bit;
   logic                  busy;

   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      input  mux_sel, ser_data, par_bit, busy
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      output mux_sel, ser_data, par_bit, busy
   );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: latches a word on acceptance, then walks
// START, DATA (LSB first), optional PARITY and STOP, one state per CLK.
module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic         CLK,
   input  logic         RST,
   uart_tx_ctrl_if.slave bus
);
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  pen_q, pen_d;
   logic                  ptyp_q, ptyp_d;
   logic                  par_q, par_d;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         pen_q   <= 1'b0;
         ptyp_q  <= 1'b0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         pen_q   <= pen_d;
         ptyp_q  <= ptyp_d;
         par_q   <= par_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      pen_d   = pen_q;
      ptyp_d  = ptyp_q;
      par_d   = par_q;
      unique case (state_q)
         IDLE: begin
            if (bus.Data_Valid) begin
               data_d  = bus.P_DATA;
               pen_d   = bus.PAR_EN;
               ptyp_d  = bus.PAR_TYP;
               par_d   = (^bus.P_DATA) ^ bus.PAR_TYP;
               state_d = START;
            end
         end
         START: begin
            cnt_d   = '0;
            state_d = DATA;
         end
         DATA: begin
            // Explicit wrap keeps non-power-of-two widths in range.
            if (cnt_q == LAST_BIT) begin
               cnt_d   = '0;
               state_d = pen_q ? PARITY : STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PARITY: state_d = STOP;
         STOP:   state_d = IDLE;
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      bus.mux_sel  = 2'b01;
      bus.ser_data = 1'b0;
      bus.busy     = (state_q != IDLE);
      bus.par_bit  = par_q;
      unique case (state_q)
         START:  bus.mux_sel = 2'b00;
         DATA: begin
            bus.mux_sel  = 2'b10;
            bus.ser_data = data_q[cnt_q];
         end
         PARITY: bus.mux_sel = 2'b11;
         default: bus.mux_sel = 2'b01;
      endcase
   end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmit path. Accepts a parallel word with a valid strobe and latches the word and its parity configuration. Then steps through START, DATA, PARITY (optional) and STOP, one state per CLK. Each cycle it drives the 2-bit output-mux select, the serial data bit and the parity bit into the registered TX output mux, and asserts busy for the whole frame.

Parameters:
DATA_WIDTH, 8, payload bits per frame (>=2)

Ports:
CLK  input  1  bit-rate clock; one CLK period = one UART bit
RST  input  1  synchronous reset, active-low
P_DATA  input  DATA_WIDTH  parallel payload; sampled only on acceptance
Data_Valid  input  1  payload valid strobe
PAR_EN  input  1  1 = parity bit inserted after data
PAR_TYP  input  1  0 = even parity, 1 = odd parity
mux_sel  output  2  00 start, 01 stop/idle, 10 serial data, 11 parity
ser_data  output  1  current data bit, LSB first
par_bit  output  1  parity of latched word
busy  output  1  frame in progress

Behaviour:
- Clock/reset: one clock, CLK. Reset is synchronous, active-low. When RST=0 at a CLK rising edge, all state returns to reset values, regardless of current state.
- Reset values: state IDLE, mux_sel=01, ser_data=0, par_bit=0, busy=0, bit counter=0, data register=0, latched PAR_EN/PAR_TYP=0.
- All outputs are decoded from registers only; no combinational path from inputs to outputs.
- States and mux_sel per state: IDLE (01), START (00), DATA (10), PARITY (11), STOP (01).
- busy = 1 in every state except IDLE.
- Acceptance: occurs at the edge where state=IDLE and Data_Valid=1.
  - Latch P_DATA, PAR_EN and PAR_TYP.
  - Compute par_bit = XOR-reduce(P_DATA) for even, or its inverse for odd.
  - Go to START.
  - Data_Valid in any non-IDLE state is ignored. Nothing is queued and the latched word is unaffected.
- Transitions:
  - START -> DATA after 1 cycle; bit counter cleared.
  - DATA: each cycle ser_data = data_reg[bit_cnt] and bit_cnt increments. After the cycle with bit_cnt = DATA_WIDTH-1, go to PARITY if the latched PAR_EN=1, else to STOP. The counter then wraps to 0.
  - PARITY -> STOP after 1 cycle.
  - STOP -> IDLE after 1 cycle.
- Frame timing, acceptance edge = cycle 0:
  - busy high for cycles 1 .. DATA_WIDTH+2 (no parity) or 1 .. DATA_WIDTH+3 (parity).
  - busy low on the following cycle.
  - The downstream mux adds one register stage, so line timing is these cycles +1.
- Back-to-back frames: Data_Valid held high in IDLE is accepted on the first IDLE cycle after STOP. Minimum one IDLE (stop/idle level) cycle between frames.
- ser_data = 0 outside DATA.
- par_bit holds its value from acceptance until the next acceptance or reset. It is valid in PARITY regardless of other states.
- PAR_EN/PAR_TYP changes mid-frame have no effect on the current frame.
- Counter width = ceil(log2(DATA_WIDTH)). Unreachable state encodings recover to IDLE on the next edge.

Test Plan:
- Even parity: PAR_EN=1, PAR_TYP=0, P_DATA=0xA5, 1-cycle Data_Valid in IDLE -> busy high 11 cycles.
  - mux_sel sequence: 00, then 10 x8, then 11, then 01.
  - ser_data during DATA = 1,0,1,0,0,1,0,1; par_bit=0.
  - Then IDLE, mux_sel=01, busy=0.
- Odd parity: same word with PAR_TYP=1 -> par_bit=1 in PARITY. Also P_DATA=0x01 even -> par_bit=1.
- No parity: PAR_EN=0, P_DATA=0x3C -> busy high 10 cycles; mux_sel never 11; STOP follows the 8th data bit directly.
- Busy collision: accept 0x55, then pulse Data_Valid with P_DATA=0xFF during DATA -> frame still serializes 0x55 bits (1,0,1,0,1,0,1,0). The 0xFF word is never sent; IDLE follows STOP.
- Back-to-back: Data_Valid held high with 0x0F then 0xF0 -> exactly one IDLE cycle (mux_sel=01, busy=0) between frames. Second frame carries 0xF0 with correct parity.
- Reset mid-frame: RST=0 during DATA (bit 3) -> after that edge state IDLE, mux_sel=01, busy=0, ser_data=0, par_bit=0. With RST=1, the next Data_Valid starts a fresh full frame.
